// File: rtl/uk101_vram_arbiter.sv
// UK101 display-RAM arbiter: fixed video slot at cnt 0..1 of every pixel slot,
// CPU accesses squeezed into the remaining cycles of the slot.
module uk101_vram_arbiter #(
    parameter int DIV = 6,
    parameter int AW  = 11
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          ce_pix
);

    localparam logic [3:0] CNT_LAST = 4'(DIV - 1);
    localparam logic [3:0] CPU_LO   = 4'd2;
    localparam logic [3:0] CPU_HI   = 4'(DIV - 2);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CPU_ADDR = 2'd1;
    localparam logic [1:0] CPU_DATA = 2'd2;
    localparam logic [1:0] CPU_ACK  = 2'd3;

    logic [3:0]    cnt_q, cnt_d;
    logic          ce_pix_q, ce_pix_d;
    logic          vid_pend_q, vid_pend_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic          vid_fetch_q, vid_fetch_d;
    logic          vid_valid_q, vid_valid_d;
    logic [7:0]    vid_data_q, vid_data_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;

    logic          vid_cyc;
    logic          cpu_start;
    logic [1:0]    cpu_state;

    assign vid_cyc   = (cnt_q == 4'd0) && vid_pend_q;
    assign cpu_start = (state_q == IDLE) && cpu_req
                    && (cnt_q >= CPU_LO) && (cnt_q <= CPU_HI);
    // The address cycle begins in the very cycle the request is accepted.
    assign cpu_state = cpu_start ? CPU_ADDR : state_q;

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
        ce_pix_d    = (cnt_q == CNT_LAST);
        vid_addr_d  = vid_req ? vid_addr : vid_addr_q;
        vid_fetch_d = vid_cyc;
        vid_valid_d = vid_fetch_q;
        vid_data_d  = vid_fetch_q ? ram_rdata : vid_data_q;
        vid_pend_d  = vid_pend_q;
        if (vid_req) begin
            vid_pend_d = 1'b1;
        end else if (vid_cyc) begin
            vid_pend_d = 1'b0;
        end
        cpu_rdata_d = cpu_rdata_q;
        if (state_q == CPU_DATA && !cpu_we) begin
            cpu_rdata_d = ram_rdata;
        end
        state_d = IDLE;
        case (cpu_state)
            CPU_ADDR: state_d = CPU_DATA;
            CPU_DATA: state_d = CPU_ACK;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        unique case (1'b1)
            vid_cyc: begin
                ram_addr = vid_addr_q;
            end
            cpu_state == CPU_ADDR: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            cpu_state == CPU_DATA: begin
                ram_addr = cpu_addr;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q       <= 4'd0;
            ce_pix_q    <= 1'b0;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            vid_fetch_q <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= 8'h00;
            state_q     <= IDLE;
            cpu_rdata_q <= 8'h00;
        end else begin
            cnt_q       <= cnt_d;
            ce_pix_q    <= ce_pix_d;
            vid_pend_q  <= vid_pend_d;
            vid_addr_q  <= vid_addr_d;
            vid_fetch_q <= vid_fetch_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign ce_pix    = ce_pix_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = (state_q == CPU_ACK);

endmodule

// File: tb/tb_uk101_vram_arbiter.sv
// Bench for uk101_vram_arbiter: synchronous RAM model, slot-counter model
// and expected-result queues for video fetches and CPU completions.
module tb_uk101_vram_arbiter;

    logic        clk;
    logic        n_reset;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        ce_pix;

    uk101_vram_arbiter #(.DIV(6), .AW(11)) dut (
        .clk(clk), .n_reset(n_reset),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ce_pix(ce_pix)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mem     [0:2047];
    logic [7:0] exp_mem [0:2047];
    logic [7:0] vq [$];
    logic [7:0] cq [$];
    logic [7:0] last_rd;
    logic [3:0] m_cnt;
    logic       m_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_cnt   <= 4'd0;
            m_first <= 1'b1;
        end else begin
            m_cnt <= (m_cnt == 4'd5) ? 4'd0 : m_cnt + 4'd1;
            if (m_cnt == 4'd5) m_first <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            chk("ce_pix", ce_pix, (m_cnt == 4'd0) && !m_first);
            chk("we_vslot", ram_we && (m_cnt <= 4'd1), 0);
            if (vid_valid) begin
                if (vq.size() != 0) begin
                    chk("vid_data", vid_data, vq.pop_front());
                    chk("vid_cnt", m_cnt, 2);
                end else begin
                    chk("vid_unexp", vid_valid, 0);
                end
            end
            if (cpu_ack) begin
                if (cq.size() != 0) begin
                    chk("cpu_rdata", cpu_rdata, cq.pop_front());
                end else begin
                    chk("ack_unexp", cpu_ack, 0);
                end
            end
        end
    end

    task automatic wait_cnt(input int k);
        int n = 0;
        @(posedge clk); #1;
        while (int'(m_cnt) != k && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic vid_pulse(input logic [10:0] a);
        vq.push_back(exp_mem[a]);
        vid_req  = 1'b1;
        vid_addr = a;
        @(posedge clk); #1;
        vid_req  = 1'b0;
        vid_addr = '0;
    endtask

    task automatic wait_vid();
        for (int i = 0; i < 20 && vq.size() != 0; i++) @(posedge clk);
        #1;
        if (vq.size() != 0) chk("vid_timeout", vq.size(), 0);
    endtask

    task automatic cpu_access(input logic we, input logic [10:0] a,
                              input logic [7:0] d, output int st_at,
                              output int ack_at, output int we_at,
                              output int we_n);
        if (we) begin
            exp_mem[a] = d;
        end else begin
            last_rd = exp_mem[a];
        end
        cq.push_back(last_rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        st_at = -1; ack_at = -1; we_at = -1; we_n = 0;
        for (int i = 0; i < 30 && ack_at < 0; i++) begin
            @(negedge clk);
            if (st_at < 0 && ram_addr == a) st_at = int'(m_cnt);
            if (ram_we) begin
                we_at = int'(m_cnt);
                we_n++;
            end
            if (cpu_ack) begin
                ack_at = int'(m_cnt);
                if (m_cnt != 4'd0) chk("ack_idle", ram_addr, 0);
            end
        end
        if (ack_at < 0) chk("cpu_timeout", cpu_ack, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ce"}, ce_pix, 0);
        chk({tag, "_vv"}, vid_valid, 0);
        chk({tag, "_vd"}, vid_data, 0);
        chk({tag, "_ack"}, cpu_ack, 0);
        chk({tag, "_rd"}, cpu_rdata, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_ra"}, ram_addr, 0);
        chk({tag, "_wd"}, ram_wdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    int st, ack, wat, wn;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            exp_mem[i] = 8'(i) ^ 8'hA5;
        end
        mem[11'h123] = 8'h41; exp_mem[11'h123] = 8'h41;
        last_rd = 8'h00;
        n_reset = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst0");
        n_reset = 1'b1;

        // idle: ce_pix cadence checked by the monitor
        repeat (14) @(posedge clk);

        // video fetch of 0x123 requested at cnt 3
        wait_cnt(3);
        vid_pulse(11'h123);
        wait_cnt(0);
        @(negedge clk);
        chk("v_addr", ram_addr, 11'h123);
        chk("v_we", ram_we, 0);
        wait_vid();

        // CPU write 0x5A to 0x7FF, then read back
        wait_cnt(0);
        cpu_access(1'b1, 11'h7FF, 8'h5A, st, ack, wat, wn);
        chk("wr_we_cnt", wat, 2);
        chk("wr_we_n", wn, 1);
        chk("wr_ack_cnt", ack, 4);
        wait_cnt(0);
        cpu_access(1'b0, 11'h7FF, 8'h00, st, ack, wat, wn);
        chk("rd_ack_cnt", ack, 4);
        chk("rd_we_n", wn, 0);

        // simultaneous video and CPU request at cnt 5
        wait_cnt(5);
        fork
            vid_pulse(11'h200);
            cpu_access(1'b0, 11'h300, 8'h00, st, ack, wat, wn);
        join
        chk("sim_st", st, 2);
        chk("sim_ack", ack, 4);
        wait_vid();

        // CPU request at cnt 5 deferred to cnt 2
        wait_cnt(5);
        cpu_access(1'b1, 11'h010, 8'h77, st, ack, wat, wn);
        chk("def_st", st, 2);
        chk("def_we", wat, 2);
        chk("def_ack", ack, 4);

        // CPU request at cnt 4 runs 4-5, ack alongside a video fetch
        wait_cnt(4);
        fork
            vid_pulse(11'h123);
            cpu_access(1'b0, 11'h010, 8'h00, st, ack, wat, wn);
        join
        chk("late_st", st, 4);
        chk("late_ack", ack, 0);
        wait_vid();

        // back-to-back video requests: newest address wins, one valid
        wait_cnt(2);
        vid_req = 1'b1; vid_addr = 11'h050;
        @(posedge clk); #1;
        vid_addr = 11'h060;
        vq.push_back(exp_mem[11'h060]);
        @(posedge clk); #1;
        vid_req = 1'b0; vid_addr = '0;
        wait_vid();
        repeat (12) @(posedge clk);

        // reset asserted during a CPU write cycle
        wait_cnt(0);
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 11'h400; cpu_wdata = 8'hEE;
        for (int i = 0; i < 10 && !ram_we; i++) @(negedge clk);
        chk("rst_we_seen", ram_we, 1);
        #1 n_reset = 1'b0;
        #1 chk("rst_we_now", ram_we, 0);
        chk("rst_ack_now", cpu_ack, 0);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vq.delete();
        cq.delete();
        last_rd = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst1");
        n_reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("rel1");
        repeat (8) @(posedge clk);
        wait_cnt(2);
        cpu_access(1'b0, 11'h400, 8'h00, st, ack, wat, wn);
        chk("post_st", st, 2);
        chk("post_ack", ack, 4);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uk101_vram_arbiter.md
UK101_VRAM_ARBITER -- requirements
Module: uk101_vram_arbiter

Interface
REQ-001 SHALL have parameter DIV, default 6: clocks per pixel slot; legal values 4..15.
REQ-002 SHALL have parameter AW, default 11: display-RAM address width (2 KB, 64x32 text).
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 vid_req  in  1  one-cycle video fetch request strobe.
REQ-006 vid_addr  in  AW  fetch address, sampled with vid_req.
REQ-007 vid_data  out  8  fetched character byte.
REQ-008 vid_valid  out  1  one-cycle strobe, vid_data valid.
REQ-009 cpu_req  in  1  level CPU access request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  AW  CPU address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_rdata  out  8  CPU read data, valid with cpu_ack.
REQ-014 cpu_ack  out  1  one-cycle completion strobe, reads and writes.
REQ-015 ram_addr  out  AW  display-RAM address.
REQ-016 ram_we  out  1  display-RAM write enable.
REQ-017 ram_wdata  out  8  display-RAM write data.
REQ-018 ram_rdata  in  8  display-RAM read data; synchronous RAM, valid the cycle after its address.
REQ-019 ce_pix  out  1  pixel clock enable, one cycle in every DIV.

Function
REQ-020 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0, advancing every clock.
REQ-021 ce_pix SHALL be registered, high exactly in cycles with cnt==0, except the first slot after reset release.
REQ-022 vid_req=1 SHALL latch vid_addr and set vid_pend at that edge; a new vid_req while vid_pend is set SHALL overwrite the address (newest wins, one vid_valid).
REQ-023 In a cycle with cnt==0 and vid_pend set, SHALL drive ram_addr = latched video address and ram_we=0 (video cycle).
REQ-024 In the following cycle (cnt==1), SHALL register ram_rdata into vid_data, clear vid_pend, and raise vid_valid for exactly the cycle with cnt==2.
REQ-025 Video fetch latency SHALL be at most DIV+2 cycles from vid_req; cycles 0..1 of every slot are reserved for video whether or not used.
REQ-026 A CPU access SHALL start in the first cycle c where cpu_req=1, no CPU access or ack is in progress, and 2<=cnt<=DIV-2.
REQ-027 Cycle c: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata; cycle c+1: ram_addr=cpu_addr, ram_we=0.
REQ-028 At the end of cycle c+1, SHALL register ram_rdata into cpu_rdata for reads (cpu_rdata unchanged for writes) and raise cpu_ack for exactly cycle c+2.
REQ-029 cpu_req still high during the cpu_ack cycle SHALL NOT start a new access in that cycle; it is a new request from the next cycle.
REQ-030 ram_we SHALL be 1 only in a CPU write cycle c; ram_addr and ram_wdata SHALL be 0 in cycles with no video or CPU access.
REQ-031 Video and CPU accesses SHALL never drive the RAM port in the same cycle; on simultaneous requests, video is served first.
REQ-032 Internal states: IDLE, CPU_ADDR (c), CPU_DATA (c+1), CPU_ACK (c+2); video is governed by cnt and vid_pend independently of the CPU state.

Reset
REQ-033 n_reset low SHALL asynchronously force cnt=0, ce_pix=0, vid_pend=0, vid_valid=0, vid_data=0, cpu_ack=0, cpu_rdata=0, state IDLE, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-034 Reset mid-access SHALL abort the access with no ack or valid issued; the requester re-issues after release.

Verification (DIV=6)
REQ-035 Release reset, no requests -> ce_pix first high at cnt==0 of the second slot, then every 6 cycles; ram_we stays 0.
REQ-036 vid_req, vid_addr=0x123 at cnt 3, RAM[0x123]=0x41 -> ram_addr=0x123 at next cnt 0; vid_valid=1, vid_data=0x41 at cnt 2.
REQ-037 CPU write 0x5A to 0x7FF, req at cnt 0 -> ram_we=1 only at cnt 2, ack at cnt 4; then CPU read 0x7FF -> cpu_rdata=0x5A with ack.
REQ-038 vid_req and cpu_req both at cnt 5 -> video at cnt 0-1, vid_valid at cnt 2; CPU at cnt 2-3, ack at cnt 4; no shared-cycle drive.
REQ-039 cpu_req at cnt 5 -> start deferred to cnt 2; cpu_req at cnt 4 -> runs cnt 4-5, ack at cnt 0, concurrent with a video fetch.
REQ-040 n_reset low during write cycle c -> ram_we=0 immediately, no cpu_ack; after release, all outputs match REQ-033.
